// File: rtl/dac_pkg.sv
// Shared definitions for the DAC setpoint ramp: state encoding, code width and
// the bounded-step next-code helper.
package dac_pkg;

    localparam int                    DAC_CODE_W          = 16;
    localparam logic [DAC_CODE_W-1:0] DAC_FULL_SCALE      = 16'hFFFF;
    localparam int                    DEFAULT_ACK_TIMEOUT = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PACE      = 3'd1,
        ISSUE     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4
    } dac_state_t;

    // One bounded move from cur toward tgt; a zero step means jump straight there.
    // The 17-bit intermediates keep the sum and difference from wrapping.
    function automatic logic [DAC_CODE_W-1:0] slew_next(
        input logic [DAC_CODE_W-1:0] cur,
        input logic [DAC_CODE_W-1:0] tgt,
        input logic [DAC_CODE_W-1:0] stp
    );
        logic [DAC_CODE_W:0] sum;
        logic [DAC_CODE_W:0] dif;
        sum = {1'b0, cur} + {1'b0, stp};
        dif = {1'b0, cur} - {1'b0, stp};
        if (sum > {1'b0, DAC_FULL_SCALE}) begin
            sum = {1'b0, DAC_FULL_SCALE};
        end
        if (stp == '0 || cur == tgt) begin
            return tgt;
        end else if (tgt > cur) begin
            return (sum >= {1'b0, tgt}) ? tgt : sum[DAC_CODE_W-1:0];
        end else begin
            return (dif[DAC_CODE_W] || dif[DAC_CODE_W-1:0] <= tgt) ? tgt : dif[DAC_CODE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/dac_ramp_tick.sv
// Pacing divider for dac_ramp: counts from 0 up to limit and holds there,
// raising tc; clear restarts the count from 0.
module dac_ramp_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DIV_W-1:0] limit,
    output logic             tc
);

    logic [DIV_W-1:0] count_q;

    assign tc = (count_q == limit);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (!tc) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/dac_ramp.sv
// Setpoint slew sequencer pacing code changes into the MCP47FEB DAC writer.
// Define DAC_RAMP_SLEW_EN to enable step limiting and the rate divider.
module dac_ramp
    import dac_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DAC_CODE_W-1:0] target,
    input  logic                  target_valid,
    output logic                  target_ready,
    input  logic [DAC_CODE_W-1:0] step,
    input  logic [DIV_W-1:0]      rate_div,
    input  logic                  dac_busy,
    output logic [DAC_CODE_W-1:0] ch_value,
    output logic                  at_target,
    output logic                  ack_err
);

    localparam int               ACK_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    dac_state_t            state_q, state_d;
    logic [DAC_CODE_W-1:0] tgt_q, ch_q, next_code;
    logic [ACK_W-1:0]      ack_cnt_q;
    logic                  ack_err_q, load_code, set_err, pace_done;

`ifdef DAC_RAMP_SLEW_EN
    logic div_clear;
    assign div_clear = (state_q != PACE);

    dac_ramp_tick #(.DIV_W(DIV_W)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (div_clear),
        .limit (rate_div),
        .tc    (pace_done)
    );

    assign next_code = slew_next(ch_q, tgt_q, step);
`else
    logic unused_cfg;
    assign unused_cfg = ^{step, rate_div};
    assign pace_done  = 1'b0;
    assign next_code  = tgt_q;
`endif

    always_comb begin
        state_d   = state_q;
        load_code = 1'b0;
        set_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tgt_q != ch_q) begin
`ifdef DAC_RAMP_SLEW_EN
                    state_d = PACE;
`else
                    state_d = ISSUE;
`endif
                end
            end
            PACE: begin
                if (pace_done) state_d = ISSUE;
            end
            ISSUE: begin
                if (!dac_busy) begin
                    load_code = 1'b1;
                    state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (dac_busy) begin
                    state_d = WAIT_DONE;
                end else if (ack_cnt_q == ACK_LAST) begin
                    set_err = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!dac_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A retarget may land in any state but ISSUE, so the code being loaded never races it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            tgt_q     <= '0;
            ch_q      <= '0;
            ack_err_q <= 1'b0;
            ack_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (target_valid && target_ready) tgt_q <= target;
            if (load_code) ch_q <= next_code;
            if (set_err) ack_err_q <= 1'b1;
            ack_cnt_q <= (state_q == WAIT_ACK) ? ack_cnt_q + 1'b1 : '0;
        end
    end

    assign target_ready = (state_q != ISSUE);
    assign ch_value     = ch_q;
    assign at_target    = (tgt_q == ch_q) && (state_q == IDLE);
    assign ack_err      = ack_err_q;

endmodule
